// File: rtl/polaris_pkg.sv
// Shared definitions for PolarisCPU data-bus responders: size codes,
// responder state encoding and the beat-count helper.
package polaris_pkg;

    localparam logic [1:0] SIZ_BYTE  = 2'd0;
    localparam logic [1:0] SIZ_HALF  = 2'd1;
    localparam logic [1:0] SIZ_WORD  = 2'd2;
    localparam logic [1:0] SIZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

    function automatic logic [2:0] beats(input logic [1:0] siz);
        case (siz)
            SIZ_BYTE:  beats = 3'd1;
            SIZ_HALF:  beats = 3'd1;
            SIZ_WORD:  beats = 3'd2;
            SIZ_DWORD: beats = 3'd4;
            default:   beats = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dbus_extend.sv
// Load-result formatter: byte lane select plus sign/zero extension of an
// assembled little-endian value. Dwords pass through unchanged.
module dbus_extend
    import polaris_pkg::*;
(
    input  logic [63:0] asm_i,
    input  logic [1:0]  siz_i,
    input  logic        signed_i,
    input  logic        adr0_i,
    output logic [63:0] data_o
);

    logic [7:0] byte_s;

    // Select the addressed byte lane, then extend to 64 bits by size.
    always_comb begin
        byte_s = 8'd0;
        data_o = 64'd0;
        if (adr0_i) begin
            byte_s = asm_i[15:8];
        end else begin
            byte_s = asm_i[7:0];
        end
        case (siz_i)
            SIZ_BYTE:  data_o = {{56{signed_i & byte_s[7]}}, byte_s};
            SIZ_HALF:  data_o = {{48{signed_i & asm_i[15]}}, asm_i[15:0]};
            SIZ_WORD:  data_o = {{32{signed_i & asm_i[31]}}, asm_i[31:0]};
            SIZ_DWORD: data_o = asm_i;
            default:   data_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/dbus_sram16.sv
// PolarisCPU D-port responder driving a 16-bit asynchronous SRAM.
// Every output is a flop loaded from next-state values, so pins never glitch.
module dbus_sram16
    import polaris_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int WAIT   = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              dcyc_i,
    input  logic              dstb_i,
    input  logic              dwe_i,
    input  logic [1:0]        dsiz_i,
    input  logic              dsigned_i,
    input  logic [63:0]       dadr_i,
    input  logic [63:0]       ddat_i,
    output logic [63:0]       ddat_o,
    output logic              dack_o,
    output logic [ADDR_W-1:0] sram_a_o,
    input  logic [15:0]       sram_d_i,
    output logic [15:0]       sram_d_o,
    output logic              sram_doe_o,
    output logic              sram_oe_o,
    output logic              sram_we_o,
    output logic [1:0]        sram_be_o
);

    localparam logic [3:0] WAIT_C = 4'(WAIT);

    state_e            state_q, state_d;
    logic              we_q, we_d, sgn_q, sgn_d;
    logic [1:0]        siz_q, siz_d, bc_q, bc_d;
    logic [3:0]        wc_q, wc_d;
    logic [ADDR_W:0]   adr_q, adr_d;
    logic [63:0]       dat_q, dat_d, asm_q, asm_d;
    logic [63:0]       ext_s, ddat_d;
    logic [ADDR_W-1:0] a_d;
    logic [15:0]       dout_d;
    logic [1:0]        be_d;
    logic              doe_d, oe_d, wen_d, dack_d, active_s, last_beat_s;
    logic              unused_s;

    assign unused_s    = ^dadr_i[63:ADDR_W+1];
    assign last_beat_s = ({1'b0, bc_q} == (beats(siz_q) - 3'd1));
    assign active_s    = (state_d == ST_SETUP) || (state_d == ST_STROBE);

    function automatic logic [ADDR_W:0] align_adr(input logic [ADDR_W:0] a, input logic [1:0] s);
        case (s)
            SIZ_BYTE:  align_adr = a;
            SIZ_HALF:  align_adr = {a[ADDR_W:1], 1'b0};
            SIZ_WORD:  align_adr = {a[ADDR_W:2], 2'b00};
            SIZ_DWORD: align_adr = {a[ADDR_W:3], 3'b000};
            default:   align_adr = a;
        endcase
    endfunction

    // Sequencer: request latch, beat/wait counting, read assembly, abort.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        siz_d   = siz_q;
        sgn_d   = sgn_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        bc_d    = bc_q;
        wc_d    = wc_q;
        asm_d   = asm_q;
        case (state_q)
            ST_IDLE: begin
                if (dcyc_i && dstb_i) begin
                    we_d    = dwe_i;
                    siz_d   = dsiz_i;
                    sgn_d   = dsigned_i;
                    adr_d   = align_adr(dadr_i[ADDR_W:0], dsiz_i);
                    dat_d   = ddat_i;
                    bc_d    = 2'd0;
                    wc_d    = 4'd0;
                    asm_d   = 64'd0;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (!dcyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    wc_d    = WAIT_C;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (!dcyc_i) begin
                    state_d = ST_IDLE;
                end else if (wc_q != 4'd0) begin
                    wc_d = wc_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        asm_d[{bc_q, 4'b0000} +: 16] = sram_d_i;
                    end else begin
                        asm_d = asm_q;
                    end
                    if (last_beat_s) begin
                        state_d = ST_ACK;
                    end else begin
                        bc_d    = bc_q + 2'd1;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    dbus_extend u_extend (
        .asm_i    (asm_d),
        .siz_i    (siz_d),
        .signed_i (sgn_d),
        .adr0_i   (adr_d[0]),
        .data_o   (ext_s)
    );

    // Next values for the pin and D-port output flops; idle pins park at zero.
    always_comb begin
        a_d    = {ADDR_W{1'b0}};
        be_d   = 2'b00;
        dout_d = 16'd0;
        doe_d  = 1'b0;
        wen_d  = 1'b0;
        oe_d   = 1'b0;
        if (active_s) begin
            a_d    = adr_d[ADDR_W:1] + ADDR_W'(bc_d);
            doe_d  = we_d;
            wen_d  = (state_d == ST_STROBE) & we_d;
            oe_d   = (state_d == ST_STROBE) & ~we_d;
            if (siz_d == SIZ_BYTE) begin
                be_d   = adr_d[0] ? 2'b10 : 2'b01;
                dout_d = {dat_d[7:0], dat_d[7:0]};
            end else begin
                be_d   = 2'b11;
                dout_d = dat_d[{bc_d, 4'b0000} +: 16];
            end
        end else begin
            a_d = {ADDR_W{1'b0}};
        end
        dack_d = (state_d == ST_ACK);
        if ((state_d == ST_ACK) && !we_d) begin
            ddat_d = ext_s;
        end else begin
            ddat_d = 64'd0;
        end
    end

    // State, request, counter and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            siz_q      <= 2'd0;
            sgn_q      <= 1'b0;
            adr_q      <= {(ADDR_W+1){1'b0}};
            dat_q      <= 64'd0;
            bc_q       <= 2'd0;
            wc_q       <= 4'd0;
            asm_q      <= 64'd0;
            sram_a_o   <= {ADDR_W{1'b0}};
            sram_be_o  <= 2'b00;
            sram_d_o   <= 16'd0;
            sram_doe_o <= 1'b0;
            sram_we_o  <= 1'b0;
            sram_oe_o  <= 1'b0;
            dack_o     <= 1'b0;
            ddat_o     <= 64'd0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            siz_q      <= siz_d;
            sgn_q      <= sgn_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            bc_q       <= bc_d;
            wc_q       <= wc_d;
            asm_q      <= asm_d;
            sram_a_o   <= a_d;
            sram_be_o  <= be_d;
            sram_d_o   <= dout_d;
            sram_doe_o <= doe_d;
            sram_we_o  <= wen_d;
            sram_oe_o  <= oe_d;
            dack_o     <= dack_d;
            ddat_o     <= ddat_d;
        end
    end

endmodule

// File: tb/tb_dbus_sram16.sv
// Self-checking bench for dbus_sram16: behavioural SRAM, vector table with a
// result/latency scoreboard, plus hand sequences for byte store, abort and reset.
module tb_dbus_sram16;

    localparam int ADDR_W = 19;
    localparam int WAIT   = 1;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              dcyc_i = 1'b0, dstb_i = 1'b0, dwe_i = 1'b0, dsigned_i = 1'b0;
    logic [1:0]        dsiz_i = 2'd0;
    logic [63:0]       dadr_i = 64'd0, ddat_i = 64'd0;
    logic [63:0]       ddat_o;
    logic              dack_o;
    logic [ADDR_W-1:0] sram_a_o;
    logic [15:0]       sram_d_i, sram_d_o;
    logic              sram_doe_o, sram_oe_o, sram_we_o;
    logic [1:0]        sram_be_o;

    dbus_sram16 #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
        .clk_i(clk), .reset_i(reset_i), .dcyc_i(dcyc_i), .dstb_i(dstb_i),
        .dwe_i(dwe_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i), .dadr_i(dadr_i),
        .ddat_i(ddat_i), .ddat_o(ddat_o), .dack_o(dack_o), .sram_a_o(sram_a_o),
        .sram_d_i(sram_d_i), .sram_d_o(sram_d_o), .sram_doe_o(sram_doe_o),
        .sram_oe_o(sram_oe_o), .sram_we_o(sram_we_o), .sram_be_o(sram_be_o)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    assign sram_d_i = mem[sram_a_o[7:0]];

    always @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'd0;
        end else if (sram_we_o) begin
            if (sram_be_o[0]) mem[sram_a_o[7:0]][7:0]  <= sram_d_o[7:0];
            if (sram_be_o[1]) mem[sram_a_o[7:0]][15:8] <= sram_d_o[15:8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       nm;
        logic        we;
        logic [1:0]  siz;
        logic        sgn;
        logic [63:0] adr;
        logic [63:0] wd;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        string       nm;
        logic [63:0] dat;
        int          k;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[15];
    int   n_chk = 0, n_pass = 0;
    int   we_cnt = 0, doe_bad = 0;
    logic [ADDR_W-1:0] last_a;
    logic [1:0]        last_be;
    logic [15:0]       last_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, req);
    endtask

    function automatic int nbeats(input logic [1:0] s);
        return (s == 2'd3) ? 4 : (s == 2'd2) ? 2 : 1;
    endfunction

    task automatic issue(input vec_t v, input bit track);
        exp_t e;
        @(negedge clk);
        dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = v.we; dsiz_i = v.siz;
        dsigned_i = v.sgn; dadr_i = v.adr; ddat_i = v.wd;
        if (track) begin
            e.nm = v.nm; e.dat = v.exp; e.k = cyc + 1; e.lat = nbeats(v.siz) * (WAIT + 2);
            sb.push_back(e);
        end
        @(negedge clk);
        dstb_i = 1'b0; dwe_i = ~v.we; dsiz_i = 2'($urandom_range(0, 3));
        dsigned_i = ~v.sgn; dadr_i = {$urandom, $urandom}; ddat_i = {$urandom, $urandom};
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        chk("ack_timeout_pending", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
        dcyc_i = 1'b0;
    endtask

    initial begin
        exp_t e;
        vec_t v;
        vecs[0]  = '{"st_half_6",    1'b1, 2'd1, 1'b0, 64'h6,  64'hDEAD_BEEF_CAFE_8001, 64'd0};
        vecs[1]  = '{"st_word_12",   1'b1, 2'd2, 1'b0, 64'h12, 64'hFFFF_0000_9234_5678, 64'd0};
        vecs[2]  = '{"st_byte_5",    1'b1, 2'd0, 1'b0, 64'h5,  64'h0000_0000_0000_77AB, 64'd0};
        vecs[3]  = '{"ld_byte_s_5",  1'b0, 2'd0, 1'b1, 64'h5,  64'd0, 64'hFFFF_FFFF_FFFF_FFAB};
        vecs[4]  = '{"ld_byte_u_5",  1'b0, 2'd0, 1'b0, 64'h5,  64'd0, 64'h0000_0000_0000_00AB};
        vecs[5]  = '{"ld_half_s_6",  1'b0, 2'd1, 1'b1, 64'h6,  64'd0, 64'hFFFF_FFFF_FFFF_8001};
        vecs[6]  = '{"ld_half_u_7",  1'b0, 2'd1, 1'b0, 64'h7,  64'd0, 64'h0000_0000_0000_8001};
        vecs[7]  = '{"ld_word_s_13", 1'b0, 2'd2, 1'b1, 64'h13, 64'd0, 64'hFFFF_FFFF_9234_5678};
        vecs[8]  = '{"ld_word_u_10", 1'b0, 2'd2, 1'b0, 64'h10, 64'd0, 64'h0000_0000_9234_5678};
        vecs[9]  = '{"st_dword_20",  1'b1, 2'd3, 1'b0, 64'h20, 64'h0123_4567_89AB_CDEF, 64'd0};
        vecs[10] = '{"ld_dword_27",  1'b0, 2'd3, 1'b1, 64'h27, 64'd0, 64'h0123_4567_89AB_CDEF};
        vecs[11] = '{"ld_byte_s_20", 1'b0, 2'd0, 1'b1, 64'h20, 64'd0, 64'hFFFF_FFFF_FFFF_FFEF};
        vecs[12] = '{"ld_half_s_26", 1'b0, 2'd1, 1'b1, 64'h26, 64'd0, 64'h0000_0000_0000_0123};
        vecs[13] = '{"st_byte_4",    1'b1, 2'd0, 1'b0, 64'h4,  64'h0000_0000_0000_005A, 64'd0};
        vecs[14] = '{"ld_half_u_4",  1'b0, 2'd1, 1'b0, 64'h4,  64'd0, 64'h0000_0000_0000_AB5A};

        // Passive monitor: scoreboard pops on dack, idle-zero check, write capture.
        fork
            forever begin
                @(negedge clk);
                if (sram_we_o) begin
                    we_cnt++; last_a = sram_a_o; last_be = sram_be_o; last_d = sram_d_o;
                    if (!sram_doe_o) doe_bad++;
                end
                if (dack_o) begin
                    if (sb.size() == 0) begin
                        chk("spurious_ack", {63'd0, dack_o}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.nm, "_data"}, ddat_o, e.dat);
                        chk({e.nm, "_latency"}, 64'(cyc - e.k), 64'(e.lat));
                    end
                end else begin
                    chk("ddat_zero_without_ack", ddat_o, 64'd0);
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({sram_a_o, sram_be_o, sram_d_o, sram_doe_o, sram_oe_o, sram_we_o, dack_o}), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // Byte store lane/data detail.
        begin
            int we0;
            we0 = we_cnt;
            v = '{"byte_store", 1'b1, 2'd0, 1'b0, 64'h5, 64'h0000_0000_0000_00AB, 64'd0};
            issue(v, 1'b1);
            wait_done();
            chk("bst_we_cycles", 64'(we_cnt - we0), 64'd2);
            chk("bst_addr", 64'(last_a), 64'd2);
            chk("bst_be", 64'(last_be), 64'b10);
            chk("bst_data", 64'(last_d), 64'hABAB);
            chk("bst_doe_during_we", 64'(doe_bad), 64'd0);
        end

        for (int i = 0; i < 15; i++) begin
            issue(vecs[i], 1'b1);
            wait_done();
        end
        chk("dword_beat0", 64'(mem[16]), 64'hCDEF);
        chk("dword_beat1", 64'(mem[17]), 64'h89AB);
        chk("dword_beat2", 64'(mem[18]), 64'h4567);
        chk("dword_beat3", 64'(mem[19]), 64'h0123);

        // Abort a dword load in the strobe of its third beat.
        v = '{"abort_dword", 1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 64'd0};
        issue(v, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("abort_in_strobe_oe", {63'd0, sram_oe_o}, 64'd1);
        chk("abort_beat2_addr", 64'(sram_a_o), 64'd18);
        dcyc_i = 1'b0;
        @(negedge clk);
        chk("abort_pins_idle", 64'({sram_a_o, sram_be_o, sram_oe_o, sram_we_o, sram_doe_o, dack_o}), 64'd0);
        repeat (20) @(negedge clk);
        v = '{"after_abort_byte", 1'b0, 2'd0, 1'b0, 64'h21, 64'd0, 64'h0000_0000_0000_00CD};
        issue(v, 1'b1);
        wait_done();

        // Reset in the middle of a word write.
        v = '{"reset_word_store", 1'b1, 2'd2, 1'b0, 64'h60, 64'h1111_2222_3333_4444, 64'd0};
        issue(v, 1'b0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (sram_we_o) begin
                    seen = 1;
                    break;
                end
                @(negedge clk);
            end
            chk("reset_test_saw_we", 64'(seen), 64'd1);
        end
        reset_i = 1'b1;
        @(negedge clk);
        chk("reset_mid_we", {63'd0, sram_we_o}, 64'd0);
        chk("reset_mid_outputs", 64'({sram_a_o, sram_be_o, sram_d_o, sram_doe_o, sram_oe_o, dack_o}), 64'd0);
        chk("reset_mid_ddat", ddat_o, 64'd0);
        reset_i = 1'b0;
        dcyc_i  = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
